uart: RTL and testbench
=======================

# uart

Full-duplex UART with independent transmitter and receiver sharing a single system clock, parameterized data width, optional even/odd parity, and programmable oversampling (Prescale CLK cycles per bit). The transmitter serializes a parallel word on request. The receiver deserializes an incoming frame and reports parity and framing errors. It sits between a parallel register/FIFO interface and the serial pins.

## Interface
- DATA_WIDTH, 8, data bits per frame
- CLK  in  1  system clock; all logic on rising edge
- RST  in  1  synchronous, active-high reset
- Prescale  in  6  CLK cycles per bit; even values 8–62 supported; 8/16/32 verified; held static while either side is busy
- parity_enable  in  1  1 = parity bit present in TX and RX frames
- parity_type  in  1  0 = even, 1 = odd
- TX_IN_P  in  DATA_WIDTH  word to transmit
- TX_IN_V  in  1  transmit request, sampled only when TX idle
- TX_OUT_S  out  1  serial output, idle 1
- TX_OUT_V  out  1  TX busy, high for the whole frame
- RX_IN_S  in  1  serial input, asynchronous
- RX_OUT_P  out  DATA_WIDTH  last good received word
- RX_OUT_V  out  1  one-cycle pulse, RX_OUT_P valid
- parity_error  out  1  one-cycle pulse, received parity mismatch
- framing_error  out  1  one-cycle pulse, stop bit sampled 0

## Operation
- Frame: start(0), DATA_WIDTH data bits LSB first, parity (if enabled), stop(1). N = DATA_WIDTH+2 bits, or +3 with parity. Each bit lasts Prescale cycles.
- Parity bit = XOR of data bits, inverted when parity_type = 1.
- TX FSM: IDLE → START → DATA → PARITY (skipped if disabled) → STOP → IDLE.
  - IDLE: TX_OUT_S = 1, TX_OUT_V = 0. TX_IN_V = 1 latches TX_IN_P plus the parity config.
  - TX_IN_V while busy is ignored (no queueing).
- RX front end: RX_IN_S passes through a 2-flop synchronizer; all RX behaviour refers to the synchronized signal.
- RX FSM: IDLE → START → DATA → PARITY (if enabled) → STOP → IDLE.
  - Per-bit edge counter runs 0..Prescale-1. A bit counter tracks data bits.
  - Each bit value is the majority of 3 samples taken at counts Prescale/2-1, Prescale/2, Prescale/2+1.
  - IDLE: synchronized input 0 → START, count = 0.
  - START: majority = 1 is a glitch → IDLE, no outputs.
  - Data shifts in LSB first.
  - Parity: computed parity is compared with the received bit. The result is held until the end of the frame.
  - STOP: at count Prescale/2+2, exactly one of the following occurs, then the FSM returns to IDLE:
    - Both checks pass: RX_OUT_P updates and RX_OUT_V pulses.
    - Otherwise: the applicable error(s) pulse (both may pulse in the same cycle), and RX_OUT_P stays unchanged.
  - Returning to IDLE early in the stop bit allows back-to-back frames. Line held low after a framing error starts a new frame.
- TX and RX are fully independent and may run simultaneously.

## Timing
- Reset (synchronous) clears both FSMs and all counters, from any state including mid-frame. Reset values:
  - TX_OUT_S = 1, TX_OUT_V = 0
  - RX_OUT_P = 0, RX_OUT_V = 0
  - parity_error = 0, framing_error = 0
  - synchronizer flops = 1
- TX handshake: TX_IN_V sampled high on edge k with TX_OUT_V = 0.
  - From edge k+1: TX_OUT_V = 1 and TX_OUT_S = start bit.
  - Bit i drives from edge k+1+i·Prescale.
  - TX_OUT_V falls at edge k+1+N·Prescale. A request on that same edge is accepted.
- TX_OUT_S and TX_OUT_V are registered (glitch-free).
- RX latency: RX_OUT_V / error pulse occurs (N-1)·Prescale + Prescale/2 + 2 cycles after the START entry edge. The synchronizer adds 2 cycles before START entry.
- All output pulses are exactly one CLK cycle wide.

## Test plan
- TX, Prescale 32, parity even: TX_IN_P = 0xA5 → TX_OUT_S = 0,1,0,1,0,0,1,0,1,0,1 (32 cycles each), TX_OUT_V high for 352 cycles. Then 0x3C → 0,0,0,1,1,1,1,0,0,0,1.
- RX, Prescale 32, parity even: drive 0, 1,0,1,0,0,1,0,1, 0, 1 at 32 cycles/bit → single RX_OUT_V pulse, RX_OUT_P = 0xA5, no errors.
- Same frame with parity_type = 1 → parity_error pulse, no RX_OUT_V, RX_OUT_P unchanged.
- Frame with stop bit 0 → framing_error pulse, no RX_OUT_V. Line then held high → FSM returns to IDLE with no further outputs.
- Glitches:
  - RX_IN_S low for 8 cycles at Prescale 32 → no outputs, FSM returns to IDLE.
  - TX_IN_V pulsed mid-frame → ignored.
- Loopback TX_OUT_S→RX_IN_S at Prescale 8, parity disabled: 0x00, 0xFF, 0x55 → each received intact. RST asserted mid-frame → all outputs return to reset values next cycle.

Source files
------------

// File: rtl/uart.sv
// uart: full-duplex UART, independent TX/RX FSMs on one clock, optional parity,
// Prescale clocks per bit, majority-of-3 mid-bit sampling on receive.
module uart #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [5:0]            Prescale,
  input  logic                  parity_enable,
  input  logic                  parity_type,
  input  logic [DATA_WIDTH-1:0] TX_IN_P,
  input  logic                  TX_IN_V,
  output logic                  TX_OUT_S,
  output logic                  TX_OUT_V,
  input  logic                  RX_IN_S,
  output logic [DATA_WIDTH-1:0] RX_OUT_P,
  output logic                  RX_OUT_V,
  output logic                  parity_error,
  output logic                  framing_error
);
  localparam int BW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                tx_state_q, tx_state_d;
  logic [5:0]            tx_cnt_q, tx_cnt_d;
  logic [BW-1:0]         tx_bit_q, tx_bit_d;
  logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d;
  logic                  tx_par_q, tx_par_d;
  logic                  tx_pen_q, tx_pen_d;
  logic                  tx_s_q, tx_s_d;
  logic                  tx_v_q, tx_v_d;

  // Serial outputs are registered from the current state, so they lag the FSM by one cycle.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_par_d   = tx_par_q;
    tx_pen_d   = tx_pen_q;
    tx_s_d     = tx_state_q == START  ? 1'b0 :
                 tx_state_q == DATA   ? tx_sh_q[0] :
                 tx_state_q == PARITY ? tx_par_q : 1'b1;
    tx_v_d     = tx_state_q != IDLE;
    if (tx_state_q == IDLE) begin
      if (TX_IN_V) begin
        tx_state_d = START;
        tx_cnt_d   = '0;
        tx_sh_d    = TX_IN_P;
        tx_par_d   = (^TX_IN_P) ^ parity_type;
        tx_pen_d   = parity_enable;
      end
    end else if (tx_cnt_q != Prescale - 6'd1) begin
      tx_cnt_d = tx_cnt_q + 6'd1;
    end else begin
      tx_cnt_d = '0;
      case (tx_state_q)
        START: begin
          tx_state_d = DATA;
          tx_bit_d   = '0;
        end
        DATA: begin
          tx_sh_d  = tx_sh_q >> 1;
          tx_bit_d = tx_bit_q + 1'b1;
          if (tx_bit_q == LAST_BIT) tx_state_d = tx_pen_q ? PARITY : STOP;
        end
        PARITY:  tx_state_d = STOP;
        default: tx_state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      tx_state_q <= IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_par_q   <= 1'b0;
      tx_pen_q   <= 1'b0;
      tx_s_q     <= 1'b1;
      tx_v_q     <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      tx_par_q   <= tx_par_d;
      tx_pen_q   <= tx_pen_d;
      tx_s_q     <= tx_s_d;
      tx_v_q     <= tx_v_d;
    end
  end

  assign TX_OUT_S = tx_s_q;
  assign TX_OUT_V = tx_v_q;

  logic [1:0]            sync_q, sync_d;
  state_t                rx_state_q, rx_state_d;
  logic [5:0]            rx_cnt_q, rx_cnt_d;
  logic [BW-1:0]         rx_bit_q, rx_bit_d;
  logic [DATA_WIDTH-1:0] rx_sh_q, rx_sh_d;
  logic [1:0]            rx_smp_q, rx_smp_d;
  logic                  rx_perr_q, rx_perr_d;
  logic [DATA_WIDTH-1:0] rx_out_q, rx_out_d;
  logic                  rx_v_q, rx_v_d;
  logic                  rx_pe_q, rx_pe_d;
  logic                  rx_fe_q, rx_fe_d;
  logic                  rx, maj, mid, last;
  logic [5:0]            half;

  // The third sample is the live input, so the bit decision lands on the count Prescale/2+1.
  always_comb begin
    sync_d     = {sync_q[0], RX_IN_S};
    rx         = sync_q[1];
    half       = {1'b0, Prescale[5:1]};
    mid        = rx_cnt_q == half + 6'd1;
    last       = rx_cnt_q == Prescale - 6'd1;
    maj        = (rx_smp_q[0] & rx_smp_q[1]) | (rx_smp_q[0] & rx) | (rx_smp_q[1] & rx);
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_smp_d   = rx_smp_q;
    rx_perr_d  = rx_perr_q;
    rx_out_d   = rx_out_q;
    rx_v_d     = 1'b0;
    rx_pe_d    = 1'b0;
    rx_fe_d    = 1'b0;
    if (rx_state_q == IDLE) begin
      if (!rx) begin
        rx_state_d = START;
        rx_cnt_d   = '0;
        rx_perr_d  = 1'b0;
      end
    end else begin
      rx_cnt_d    = last ? '0 : rx_cnt_q + 6'd1;
      rx_smp_d[0] = rx_cnt_q == half - 6'd1 ? rx : rx_smp_q[0];
      rx_smp_d[1] = rx_cnt_q == half ? rx : rx_smp_q[1];
      case (rx_state_q)
        START: begin
          if (mid && maj) rx_state_d = IDLE;
          else if (last) begin
            rx_state_d = DATA;
            rx_bit_d   = '0;
          end
        end
        DATA: begin
          if (mid) rx_sh_d = {maj, rx_sh_q[DATA_WIDTH-1:1]};
          if (last) begin
            rx_bit_d = rx_bit_q + 1'b1;
            if (rx_bit_q == LAST_BIT) rx_state_d = parity_enable ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (mid) rx_perr_d = maj ^ (^rx_sh_q) ^ parity_type;
          if (last) rx_state_d = STOP;
        end
        default: begin
          if (mid) begin
            rx_state_d = IDLE;
            rx_v_d     = maj && !rx_perr_q;
            rx_out_d   = rx_v_d ? rx_sh_q : rx_out_q;
            rx_pe_d    = rx_perr_q;
            rx_fe_d    = !maj;
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q     <= 2'b11;
      rx_state_q <= IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_smp_q   <= '0;
      rx_perr_q  <= 1'b0;
      rx_out_q   <= '0;
      rx_v_q     <= 1'b0;
      rx_pe_q    <= 1'b0;
      rx_fe_q    <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_smp_q   <= rx_smp_d;
      rx_perr_q  <= rx_perr_d;
      rx_out_q   <= rx_out_d;
      rx_v_q     <= rx_v_d;
      rx_pe_q    <= rx_pe_d;
      rx_fe_q    <= rx_fe_d;
    end
  end

  assign RX_OUT_P      = rx_out_q;
  assign RX_OUT_V      = rx_v_q;
  assign parity_error  = rx_pe_q;
  assign framing_error = rx_fe_q;
endmodule

// File: tb/tb_uart.sv
// tb_uart: randomized self-checking bench for uart against a frame-level reference model.
module tb_uart;
  logic       CLK = 1'b0;
  logic       RST;
  logic [5:0] Prescale;
  logic       parity_enable, parity_type;
  logic [7:0] TX_IN_P;
  logic       TX_IN_V;
  logic       TX_OUT_S, TX_OUT_V;
  logic       rx_drv, loop, rx_line;
  logic [7:0] RX_OUT_P;
  logic       RX_OUT_V, parity_error, framing_error;

  int         checks = 0, failures = 0;
  int         P;
  logic [7:0] last_good = 8'h00;
  bit         frame_q[$];
  bit         line_q[$];

  assign rx_line = loop ? TX_OUT_S : rx_drv;

  uart #(.DATA_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .Prescale(Prescale),
    .parity_enable(parity_enable), .parity_type(parity_type),
    .TX_IN_P(TX_IN_P), .TX_IN_V(TX_IN_V), .TX_OUT_S(TX_OUT_S), .TX_OUT_V(TX_OUT_V),
    .RX_IN_S(rx_line), .RX_OUT_P(RX_OUT_P), .RX_OUT_V(RX_OUT_V),
    .parity_error(parity_error), .framing_error(framing_error)
  );

  always #5 CLK = ~CLK;

  function automatic bit exp_par(input logic [7:0] d);
    return (^d) ^ parity_type;
  endfunction

  task automatic build_frame(input logic [7:0] d, input bit par_bit, input bit stop_bit);
    frame_q.delete();
    frame_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) frame_q.push_back(d[i]);
    if (parity_enable) frame_q.push_back(par_bit);
    frame_q.push_back(stop_bit);
  endtask

  task automatic set_cfg(input int p, input bit pe, input bit pt);
    P = p;
    Prescale = 6'(p);
    parity_enable = pe;
    parity_type = pt;
  endtask

  task automatic test_reset();
    checks += 6;
    if (TX_OUT_S !== 1'b1) begin failures++; $display("FAIL reset_tx_s got=%b exp=1", TX_OUT_S); end
    if (TX_OUT_V !== 1'b0) begin failures++; $display("FAIL reset_tx_v got=%b exp=0", TX_OUT_V); end
    if (RX_OUT_P !== 8'h00) begin failures++; $display("FAIL reset_rx_p got=%h exp=00", RX_OUT_P); end
    if (RX_OUT_V !== 1'b0) begin failures++; $display("FAIL reset_rx_v got=%b exp=0", RX_OUT_V); end
    if (parity_error !== 1'b0) begin failures++; $display("FAIL reset_perr got=%b exp=0", parity_error); end
    if (framing_error !== 1'b0) begin failures++; $display("FAIL reset_ferr got=%b exp=0", framing_error); end
  endtask

  // Frame starts on the edge after the accepting edge; busy lasts exactly n*P cycles.
  task automatic run_tx(input logic [7:0] d, input bit chained_in, input bit chain_out,
                        input logic [7:0] nd, input bit glitch);
    int n, bad_s, bad_v, vcount;
    logic exp_s, exp_v, got_s, got_v, want_s, want_v;
    build_frame(d, exp_par(d), 1'b1);
    n = frame_q.size();
    if (!chained_in) begin
      TX_IN_P = d;
      TX_IN_V = 1'b1;
      @(posedge CLK); #1;
    end
    TX_IN_V = 1'b0;
    bad_s = -1; bad_v = -1; vcount = 0;
    got_s = 0; got_v = 0; want_s = 0; want_v = 0;
    for (int j = 0; j <= n * P + 1; j++) begin
      if (j > 0) begin @(posedge CLK); #1; end
      exp_v = j >= 1 && j <= n * P;
      exp_s = exp_v ? frame_q[(j - 1) / P] : 1'b1;
      if (TX_OUT_S !== exp_s && bad_s < 0) begin bad_s = j; got_s = TX_OUT_S; want_s = exp_s; end
      if (TX_OUT_V !== exp_v && bad_v < 0) begin bad_v = j; got_v = TX_OUT_V; want_v = exp_v; end
      if (TX_OUT_V === 1'b1) vcount++;
      if (glitch && j == 3 * P) begin TX_IN_V = 1'b1; TX_IN_P = ~d; end
      if (glitch && j == 3 * P + 1) TX_IN_V = 1'b0;
      if (chain_out && j == n * P) begin TX_IN_V = 1'b1; TX_IN_P = nd; end
    end
    checks += 3;
    if (bad_s >= 0) begin
      failures++;
      $display("FAIL tx_serial data=%h cycle=%0d got=%b exp=%b", d, bad_s, got_s, want_s);
    end
    if (bad_v >= 0) begin
      failures++;
      $display("FAIL tx_busy data=%h cycle=%0d got=%b exp=%b", d, bad_v, got_v, want_v);
    end
    if (vcount != n * P) begin
      failures++;
      $display("FAIL tx_busy_len data=%h got=%0d exp=%0d", d, vcount, n * P);
    end
  endtask

  task automatic drive_line(output int nv, output int npe, output int nfe,
                            output int fv, output int fpe, output int ffe);
    nv = 0; npe = 0; nfe = 0; fv = -1; fpe = -1; ffe = -1;
    for (int j = 0; j < line_q.size(); j++) begin
      @(posedge CLK); #1;
      if (RX_OUT_V === 1'b1) begin nv++; if (fv < 0) fv = j; end
      if (parity_error === 1'b1) begin npe++; if (fpe < 0) fpe = j; end
      if (framing_error === 1'b1) begin nfe++; if (ffe < 0) ffe = j; end
      rx_drv = line_q[j];
    end
    rx_drv = 1'b1;
  endtask

  // Outputs expected L+3 iterations in: one drive lag, two synchronizer flops, then L.
  task automatic run_rx(input logic [7:0] d, input bit par_bit, input bit stop_bit);
    int n, lat, nv, npe, nfe, fv, fpe, ffe;
    bit v_exp, pe_exp, fe_exp;
    build_frame(d, par_bit, stop_bit);
    n = frame_q.size();
    line_q.delete();
    foreach (frame_q[i]) repeat (P) line_q.push_back(frame_q[i]);
    repeat (2 * P) line_q.push_back(1'b1);
    pe_exp = parity_enable && par_bit != exp_par(d);
    fe_exp = !stop_bit;
    v_exp = !pe_exp && !fe_exp;
    lat = (n - 1) * P + P / 2 + 2 + 3;
    drive_line(nv, npe, nfe, fv, fpe, ffe);
    if (v_exp) last_good = d;
    checks += 4;
    if (nv != int'(v_exp)) begin failures++; $display("FAIL rx_valid_count data=%h got=%0d exp=%0d", d, nv, v_exp); end
    if (npe != int'(pe_exp)) begin failures++; $display("FAIL rx_perr_count data=%h got=%0d exp=%0d", d, npe, pe_exp); end
    if (nfe != int'(fe_exp)) begin failures++; $display("FAIL rx_ferr_count data=%h got=%0d exp=%0d", d, nfe, fe_exp); end
    if (RX_OUT_P !== last_good) begin failures++; $display("FAIL rx_data data=%h got=%h exp=%h", d, RX_OUT_P, last_good); end
    if (v_exp) begin
      checks++;
      if (fv != lat) begin failures++; $display("FAIL rx_valid_time data=%h got=%0d exp=%0d", d, fv, lat); end
    end
    if (pe_exp) begin
      checks++;
      if (fpe != lat) begin failures++; $display("FAIL rx_perr_time data=%h got=%0d exp=%0d", d, fpe, lat); end
    end
    if (fe_exp) begin
      checks++;
      if (ffe != lat) begin failures++; $display("FAIL rx_ferr_time data=%h got=%0d exp=%0d", d, ffe, lat); end
    end
  endtask

  task automatic test_tx_directed();
    set_cfg(32, 1'b1, 1'b0);
    run_tx(8'hA5, 1'b0, 1'b0, 8'h00, 1'b0);
    run_tx(8'h3C, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_tx_ignore_busy();
    set_cfg(16, 1'b1, 1'b1);
    run_tx(8'($urandom), 1'b0, 1'b0, 8'h00, 1'b1);
    checks++;
    repeat (3) @(posedge CLK);
    #1;
    if (TX_OUT_V !== 1'b0) begin failures++; $display("FAIL tx_no_queue got=%b exp=0", TX_OUT_V); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a, b;
    a = 8'($urandom);
    b = 8'($urandom);
    set_cfg(16, 1'b0, 1'b0);
    run_tx(a, 1'b0, 1'b1, b, 1'b0);
    run_tx(b, 1'b1, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_tx_random();
    for (int i = 0; i < 3; i++) begin
      set_cfg(8 << $urandom_range(0, 2), 1'($urandom), 1'($urandom));
      run_tx(8'($urandom), 1'b0, 1'b0, 8'h00, 1'b0);
    end
  endtask

  task automatic test_rx_directed();
    set_cfg(32, 1'b1, 1'b0);
    run_rx(8'hA5, 1'b0, 1'b1);
    parity_type = 1'b1;
    run_rx(8'hA5, 1'b0, 1'b1);
    parity_type = 1'b0;
    run_rx(8'hA5, 1'b0, 1'b0);
    run_rx(8'h96, 1'b1, 1'b0);
  endtask

  task automatic test_rx_glitch();
    int nv, npe, nfe, fv, fpe, ffe;
    set_cfg(32, 1'b1, 1'b0);
    line_q.delete();
    repeat (8) line_q.push_back(1'b0);
    repeat (2 * P) line_q.push_back(1'b1);
    drive_line(nv, npe, nfe, fv, fpe, ffe);
    checks++;
    if (nv + npe + nfe != 0) begin
      failures++;
      $display("FAIL rx_glitch pulses got=%0d exp=0", nv + npe + nfe);
    end
    run_rx(8'h3C, 1'b0, 1'b1);
  endtask

  task automatic test_rx_random();
    logic [7:0] d;
    int err;
    for (int i = 0; i < 8; i++) begin
      set_cfg(8 << $urandom_range(0, 2), 1'($urandom), 1'($urandom));
      d = 8'($urandom);
      err = $urandom_range(0, 2);
      run_rx(d, exp_par(d) ^ (err == 1), err != 2);
    end
  endtask

  task automatic test_loopback();
    logic [7:0] vals [3];
    bit got;
    vals = '{8'h00, 8'hFF, 8'h55};
    set_cfg(8, 1'b0, 1'b0);
    loop = 1'b1;
    foreach (vals[i]) begin
      TX_IN_P = vals[i];
      TX_IN_V = 1'b1;
      @(posedge CLK); #1;
      TX_IN_V = 1'b0;
      got = 0;
      for (int c = 0; c < 20 * P && !got; c++) begin
        @(posedge CLK); #1;
        got = RX_OUT_V === 1'b1 || parity_error === 1'b1 || framing_error === 1'b1;
      end
      checks += 2;
      if (!(got && RX_OUT_V === 1'b1 && parity_error === 1'b0 && framing_error === 1'b0)) begin
        failures++;
        $display("FAIL loop_valid data=%h got=%b/%b/%b/%b exp=1/1/0/0", vals[i], got, RX_OUT_V, parity_error, framing_error);
      end
      if (RX_OUT_P !== vals[i]) begin failures++; $display("FAIL loop_data got=%h exp=%h", RX_OUT_P, vals[i]); end
      for (int c = 0; c < 4 * P && TX_OUT_V !== 1'b0; c++) begin @(posedge CLK); #1; end
      repeat (2) @(posedge CLK);
      #1;
    end
  endtask

  task automatic test_reset_mid();
    int extra;
    TX_IN_P = 8'h5A;
    TX_IN_V = 1'b1;
    @(posedge CLK); #1;
    TX_IN_V = 1'b0;
    repeat (40) @(posedge CLK);
    #1;
    checks++;
    if (TX_OUT_V !== 1'b1) begin failures++; $display("FAIL mid_busy got=%b exp=1", TX_OUT_V); end
    RST = 1'b1;
    @(posedge CLK); #1;
    test_reset();
    RST = 1'b0;
    extra = 0;
    for (int c = 0; c < 200; c++) begin
      @(posedge CLK); #1;
      if (RX_OUT_V === 1'b1 || parity_error === 1'b1 || framing_error === 1'b1 || TX_OUT_V === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin failures++; $display("FAIL post_reset_quiet got=%0d exp=0", extra); end
    loop = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    TX_IN_V = 1'b0;
    TX_IN_P = 8'h00;
    rx_drv = 1'b1;
    loop = 1'b0;
    set_cfg(32, 1'b1, 1'b0);
    repeat (3) @(posedge CLK);
    #1;
    test_reset();
    RST = 1'b0;
    @(posedge CLK); #1;
    test_tx_directed();
    test_tx_ignore_busy();
    test_back_to_back();
    test_tx_random();
    test_rx_directed();
    test_rx_glitch();
    test_rx_random();
    test_loopback();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
